// File: rtl/encoder16x4_drain.sv
// Sequential 16-to-4 priority encoder: drains a request vector one set-bit index per beat.
// Latency: first index valid the cycle after acceptance, then 1 index/cycle while out_ready=1.
// Backpressure: out/out_last hold while out_valid && !out_ready; err port only with ENC_ONEHOT_CHK_EN.
module encoder16x4_drain #(
  parameter int N_IN         = 16,
  parameter int W_OUT        = 4,
  parameter bit PRIORITY_LSB = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_OUT-1:0] out,
  output logic             out_last,
  output logic             busy
`ifdef ENC_ONEHOT_CHK_EN
  ,
  output logic             err
`endif
);

  typedef enum logic [0:0] {IDLE, DRAIN} state_t;

  state_t            state, state_d;
  logic [N_IN-1:0]   pending, pending_d;
  logic [W_OUT-1:0]  out_d;
  logic              out_last_d;
  logic              out_valid_d;
  logic              accept;

  function automatic logic [W_OUT-1:0] prio_idx(input logic [N_IN-1:0] v);
    prio_idx = '0;
    // Last match wins, so scan order picks the priority end.
    if (PRIORITY_LSB) begin
      for (int i = N_IN - 1; i >= 0; i--)
        if (v[i]) prio_idx = W_OUT'(i);
    end else begin
      for (int i = 0; i < N_IN; i++)
        if (v[i]) prio_idx = W_OUT'(i);
    end
  endfunction

  function automatic logic single_bit(input logic [N_IN-1:0] v);
    single_bit = (v != '0) && ((v & (v - N_IN'(1))) == '0);
  endfunction

  assign in_ready = (state == IDLE);
  assign accept   = in_ready && in_valid;

  always_comb begin
    state_d   = state;
    pending_d = pending;
    case (state)
      IDLE: begin
        if (accept && (in != '0)) begin
          pending_d = in;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          pending_d = pending & ~(N_IN'(1) << out);
          if (out_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next pending value, so they reflect it one cycle later.
    out_valid_d = (state_d == DRAIN);
    out_d       = out_valid_d ? prio_idx(pending_d) : '0;
    out_last_d  = out_valid_d && single_bit(pending_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= '0;
      out       <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      pending   <= pending_d;
      out       <= out_d;
      out_last  <= out_last_d;
      out_valid <= out_valid_d;
      busy      <= out_valid_d;
    end
  end

`ifdef ENC_ONEHOT_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else     err <= accept && ((in & (in - N_IN'(1))) != '0);
  end
`endif

endmodule

// File: tb/tb_encoder16x4_drain.sv
// Directed bench for encoder16x4_drain: hand-computed beats, sampled on the falling edge.
module tb_encoder16x4_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] vec;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out;
  logic        out_last;
  logic        busy;
`ifdef ENC_ONEHOT_CHK_EN
  logic        err;
`endif

  int cmp_cnt = 0;
  int mis_cnt = 0;

  always #5 clk = ~clk;

  encoder16x4_drain dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_last  (out_last),
    .busy      (busy)
`ifdef ENC_ONEHOT_CHK_EN
    ,
    .err       (err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Check one drain beat: out_valid, index and last flag.
  task automatic beat(input string tag, input int idx, input bit last);
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_idx"}, 32'(out), 32'(idx));
    chk({tag, "_last"}, 32'(out_last), 32'(last));
  endtask

  initial begin
    int exp3 [4];
    exp3 = '{0, 5, 10, 15};
    rst = 1'b1; in_valid = 1'b0; vec = '0; out_ready = 1'b0;

    // 1: reset
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    chk("rst_ovld", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_irdy", 32'(in_ready), 32'd1);
`ifdef ENC_ONEHOT_CHK_EN
    chk("rst_err", 32'(err), 32'd0);
`endif

    // 2: single low bit
    vec = 16'h0001; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    beat("t2", 0, 1'b1);
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_irdy", 32'(in_ready), 32'd0);
    cyc();
    chk("t2_idle_vld", 32'(out_valid), 32'd0);
    chk("t2_idle_irdy", 32'(in_ready), 32'd1);

    // 3: four set bits, full throughput
    vec = 16'h8421; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      beat($sformatf("t3_b%0d", k), exp3[k], k == 3);
      cyc();
    end
    chk("t3_done", 32'(out_valid), 32'd0);

    // 4: backpressure, plus a vector offered mid-drain
    vec = 16'h0030; in_valid = 1'b1; out_ready = 1'b0;
    cyc();
    vec = 16'h00FF;
    for (int k = 0; k < 4; k++) begin
      beat($sformatf("t4_hold%0d", k), 4, 1'b0);
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    beat("t4_b0", 4, 1'b0);
    cyc();
    beat("t4_b1", 5, 1'b1);
    cyc();
    chk("t4_done", 32'(out_valid), 32'd0);
    cyc();
    chk("t4_nocap", 32'(out_valid), 32'd0);
    chk("t4_irdy", 32'(in_ready), 32'd1);

    // 5: zero vector is dropped; then a two-bit vector
    vec = 16'h0000; in_valid = 1'b1;
    repeat (2) begin
      cyc();
      chk("t5_zvld", 32'(out_valid), 32'd0);
      chk("t5_zbusy", 32'(busy), 32'd0);
      chk("t5_zirdy", 32'(in_ready), 32'd1);
`ifdef ENC_ONEHOT_CHK_EN
      chk("t5_zerr", 32'(err), 32'd0);
`endif
    end
    vec = 16'h0300;
    cyc();
    in_valid = 1'b0;
    beat("t5_b0", 8, 1'b0);
`ifdef ENC_ONEHOT_CHK_EN
    chk("t5_err1", 32'(err), 32'd1);
`endif
    cyc();
    beat("t5_b1", 9, 1'b1);
`ifdef ENC_ONEHOT_CHK_EN
    chk("t5_err0", 32'(err), 32'd0);
`endif
    cyc();
    chk("t5_done", 32'(out_valid), 32'd0);

    // 6: reset in the middle of a full-vector drain
    vec = 16'hFFFF; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      beat($sformatf("t6_b%0d", k), k, 1'b0);
      cyc();
    end
    beat("t6_b3", 3, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_rvld", 32'(out_valid), 32'd0);
    chk("t6_rbusy", 32'(busy), 32'd0);
    chk("t6_rout", 32'(out), 32'd0);
    cyc();
    chk("t6_irdy", 32'(in_ready), 32'd1);
    vec = 16'h0004; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    beat("t6_new", 2, 1'b1);
    cyc();
    chk("t6_done", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
